// File: rtl/uart_frame_sender.sv
// uart_frame_sender
// Periodic telemetry frame transmitter feeding a UART TX byte interface.
// Frame layout: HEADER, sample[15:8], sample[7:0], status, and an optional
// checksum byte (byte1 ^ byte2 ^ byte3) when FRAME_CHECKSUM_EN is defined.
// Status byte: bit0 = sample > thr_hi, bit1 = sample < thr_lo (unsigned),
// computed once per frame from the snapshot taken in LOAD.
// All outputs are registered; tx_start is a one-cycle pulse issued only
// after tx_busy has been observed low.
module uart_frame_sender #(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 24,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_send,
  input  logic        stop_send,
  input  logic [15:0] sample_data,
  input  logic [15:0] thr_hi,
  input  logic [15:0] thr_lo,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        armed,
  output logic        frame_done
);

`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  // Counter reload gives PERIOD_CYCLES cycles from one LOAD to the next.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [15:0]       sample_q, sample_d;
  logic [7:0]        status_q, status_d;
  logic              armed_q, armed_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        status_now;
  logic [7:0]        cur_byte;
  logic              period_up;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        csum_now;
`endif

  // Status byte derived from the live sample; only latched during LOAD.
  assign status_now = {6'b000000, (sample_data < thr_lo), (sample_data > thr_hi)};

`ifdef FRAME_CHECKSUM_EN
  assign csum_now = sample_data[15:8] ^ sample_data[7:0] ^ status_now;
`endif

  // Armed flag: stop_send dominates en_send; re-arming while armed is a no-op.
  always_comb begin
    armed_d = armed_q;
    if (stop_send) begin
      armed_d = 1'b0;
    end else if (en_send) begin
      armed_d = 1'b1;
    end
  end

  // Period counter: reloaded in LOAD, otherwise counts down and sticks at 0.
  always_comb begin
    if (state_q == LOAD) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q == '0) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // The counter reaches 0 on this edge, so the next LOAD lands exactly
  // PERIOD_CYCLES after the previous one (or immediately if already overdue).
  assign period_up = (cnt_d == '0);

  // Byte selected by the current index from the frame snapshot.
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = sample_q[15:8];
      3'd2:    cur_byte = sample_q[7:0];
      3'd3:    cur_byte = status_q;
`ifdef FRAME_CHECKSUM_EN
      3'd4:    cur_byte = csum_q;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  // Frame sequencer: next state and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sample_d     = sample_q;
    status_d     = status_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (armed_d) begin
          state_d = LOAD;
        end
      end
      WAIT_PERIOD: begin
        if (!armed_q) begin
          state_d = IDLE;
        end else if (period_up) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        sample_d = sample_data;
        status_d = status_now;
`ifdef FRAME_CHECKSUM_EN
        csum_d   = csum_now;
`endif
        idx_d    = 3'd0;
        state_d  = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end else begin
            frame_done_d = 1'b1;
            state_d      = WAIT_PERIOD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      sample_q     <= 16'h0000;
      status_q     <= 8'h00;
      armed_q      <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sample_q     <= sample_d;
      status_q     <= status_d;
      armed_q      <= armed_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign armed      = armed_q;
  assign frame_done = frame_done_q;

endmodule
